// File: rtl/mm_pkg.sv
// Shared types and constants for the interleaved modular multiplication controller.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MULT,
        SUB1,
        SUB2,
        DONE
    } mm_state_t;

    // One mult plus two conditional subtractions per multiplier bit.
    localparam int unsigned CYCLES_PER_BIT = 3;

    function automatic int unsigned iter_width(input int unsigned nbits);
        return $clog2(nbits) + 1;
    endfunction

endpackage

// File: rtl/mm_interleave_ctrl.sv
// Control FSM for interleaved modular multiplication P = X*Y mod M.
// Optional macro MM_EARLY_SKIP_EN: skip SUB2 when SUB1 saw P < M (data-dependent latency).
module mm_interleave_ctrl
    import mm_pkg::*;
#(
    parameter int unsigned n = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     p_ge_m,
    output logic                     p_clr,
    output logic                     mult,
    output logic                     sub,
    output logic [iter_width(n)-1:0] iter,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned    IW        = iter_width(n);
    localparam logic [IW-1:0]  ITER_INIT = IW'(n);

    mm_state_t     state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          last_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= ITER_INIT;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    assign last_bit = (iter_q == IW'(1));

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        p_clr   = 1'b0;
        mult    = 1'b0;
        sub     = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                p_clr   = 1'b1;
                iter_d  = ITER_INIT;
                state_d = MULT;
            end
            MULT: begin
                mult    = 1'b1;
                state_d = SUB1;
            end
            SUB1: begin
                sub     = p_ge_m;
                state_d = SUB2;
`ifdef MM_EARLY_SKIP_EN
                // P < M already, so a second subtraction cannot be needed.
                if (!p_ge_m) begin
                    if (last_bit) begin
                        state_d = DONE;
                    end else begin
                        iter_d  = iter_q - IW'(1);
                        state_d = MULT;
                    end
                end
`endif
            end
            SUB2: begin
                sub = p_ge_m;
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    iter_d  = iter_q - IW'(1);
                    state_d = MULT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_mm_interleave_ctrl.sv
// Bench: controller plus a behavioural P register and >= comparator, for n=8 and n=16.
module tb_mm_interleave_ctrl;
    import mm_pkg::*;

    localparam int unsigned N8   = 8;
    localparam int unsigned N16  = 16;
    localparam int unsigned IW8  = iter_width(N8);
    localparam int unsigned IW16 = iter_width(N16);

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start8 = 1'b0;
    logic start16 = 1'b0;

    logic [63:0] x8 = '0, y8 = '0, m8 = 64'd1, p8 = '0;
    logic [63:0] x16 = '0, y16 = '0, m16 = 64'd1, p16 = '0;
    logic        pge8, pge16;
    logic        p_clr8, mult8, sub8, busy8, done8;
    logic        p_clr16, mult16, sub16, busy16, done16;
    logic [IW8-1:0]  iter8;
    logic [IW16-1:0] iter16;

    int total = 0;
    int bad   = 0;
    int n_mult = 0, n_sub = 0, multi_hot8 = 0, multi_hot16 = 0;
    int iter_log[16];

    always #5 clk = ~clk;

    mm_interleave_ctrl #(.n(N8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .p_ge_m(pge8),
        .p_clr(p_clr8), .mult(mult8), .sub(sub8), .iter(iter8),
        .busy(busy8), .done(done8)
    );

    mm_interleave_ctrl #(.n(N16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .p_ge_m(pge16),
        .p_clr(p_clr16), .mult(mult16), .sub(sub16), .iter(iter16),
        .busy(busy16), .done(done16)
    );

    // Datapath models: P register with comparator against M.
    assign pge8  = (p8 >= m8);
    assign pge16 = (p16 >= m16);

    always @(posedge clk) begin
        int idx;
        idx = int'(iter8) - 1;
        if (p_clr8) p8 <= '0;
        else if (mult8) p8 <= (p8 << 1) + ((idx >= 0 && idx < 64 && x8[idx]) ? y8 : 64'd0);
        else if (sub8) p8 <= p8 - m8;
    end

    always @(posedge clk) begin
        int idx;
        idx = int'(iter16) - 1;
        if (p_clr16) p16 <= '0;
        else if (mult16) p16 <= (p16 << 1) + ((idx >= 0 && idx < 64 && x16[idx]) ? y16 : 64'd0);
        else if (sub16) p16 <= p16 - m16;
    end

    always @(negedge clk) begin
        if (int'(p_clr8) + int'(mult8) + int'(sub8) > 1) multi_hot8++;
        if (int'(p_clr16) + int'(mult16) + int'(sub16) > 1) multi_hot16++;
        if (mult8) begin
            if (n_mult < 16) iter_log[n_mult] = int'(iter8);
            n_mult++;
        end
        if (sub8) n_sub++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference algorithm: result, number of subtractions and start-to-done latency.
    function automatic void ref_mm(input longint x, input longint y, input longint m,
                                   input int nb, output longint p, output int subs,
                                   output int lat);
        p = 0; subs = 0; lat = 2;
        for (int i = nb - 1; i >= 0; i--) begin
            p = 2 * p + (((x >> i) & 1) != 0 ? y : 0);
            lat += 2;
            if (p >= m) begin
                p -= m; subs++; lat += 1;
                if (p >= m) begin
                    p -= m; subs++;
                end
            end else begin
`ifndef MM_EARLY_SKIP_EN
                lat += 1;
`endif
            end
        end
    endfunction

    task automatic run8(input longint x, input longint y, input longint m, input bit poke,
                        output longint p, output int lat);
        bit seen;
        @(negedge clk);
        x8 = x; y8 = y; m8 = m;
        n_mult = 0; n_sub = 0;
        start8 = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start8 = 1'b0;
            if (poke && lat == 10) start8 = 1'b1;
            if (poke && lat == 11) start8 = 1'b0;
            if (done8) seen = 1;
        end
        if (!seen) chk("run8_timeout", 0, 1);
        p = longint'(p8);
    endtask

    task automatic run16(input longint x, input longint y, input longint m,
                         output longint p, output int lat);
        bit seen;
        @(negedge clk);
        x16 = x; y16 = y; m16 = m;
        start16 = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start16 = 1'b0;
            if (done16) seen = 1;
        end
        if (!seen) chk("run16_timeout", 0, 1);
        p = longint'(p16);
    endtask

    typedef struct {
        longint x;
        longint y;
        longint m;
        longint exp_p;
        int     exp_lat;
        bit     poke;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t   vecs[7];
        longint p, rp;
        int     lat, rsubs, rlat, exp_lat;
        bit     ok, found;

        vecs[0] = '{x: 5,    y: 7,    m: 11,   exp_p: 2,   exp_lat: 26, poke: 0};
        vecs[1] = '{x: 255,  y: 254,  m: 255,  exp_p: 0,   exp_lat: 26, poke: 0};
        vecs[2] = '{x: 0,    y: 9,    m: 13,   exp_p: 0,   exp_lat: 26, poke: 0};
        vecs[3] = '{x: 3,    y: 4,    m: 7,    exp_p: 5,   exp_lat: 26, poke: 0};
        vecs[4] = '{x: 10,   y: 10,   m: 11,   exp_p: 1,   exp_lat: 26, poke: 1};
        vecs[5] = '{x: 200,  y: 100,  m: 251,  exp_p: 171, exp_lat: 26, poke: 0};
        vecs[6] = '{x: 254,  y: 253,  m: 255,  exp_p: 2,   exp_lat: 26, poke: 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_strobes8", {p_clr8, mult8, sub8}, 0);
        chk("rst_iter8", iter8, 8);
        chk("rst_iter16", iter16, 16);
        chk("rst_busy16", busy16, 0);

        foreach (vecs[i]) begin
            ref_mm(vecs[i].x, vecs[i].y, vecs[i].m, 8, rp, rsubs, rlat);
`ifdef MM_EARLY_SKIP_EN
            exp_lat = rlat;
`else
            exp_lat = vecs[i].exp_lat;
`endif
            run8(vecs[i].x, vecs[i].y, vecs[i].m, vecs[i].poke, p, lat);
            chk($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat);
            chk($sformatf("vec%0d_mult_count", i), n_mult, 8);
            ok = 1;
            for (int k = 0; k < 8; k++) if (iter_log[k] != 8 - k) ok = 0;
            chk($sformatf("vec%0d_iter_seq", i), ok, 1);
            chk($sformatf("vec%0d_sub_count", i), n_sub, rsubs);
            if (vecs[i].x == 0) chk($sformatf("vec%0d_no_sub", i), n_sub, 0);
        end

        // Start asserted in the DONE cycle is ignored.
        run8(5, 7, 11, 0, p, lat);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", busy8, 0);

        // Reset during SUB1 of bit iter=4 aborts to IDLE.
        @(negedge clk);
        x8 = 5; y8 = 7; m8 = 11;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (mult8 && iter8 == 4) found = 1;
            else @(negedge clk);
        end
        chk("reach_iter4", found, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_strobes", {p_clr8, mult8, sub8, done8}, 0);
        chk("abort_iter", iter8, 8);
        run8(5, 7, 11, 0, p, lat);
        chk("after_abort_p", p, 2);

        // Start held high: back-to-back operations with one IDLE cycle between.
        ref_mm(5, 7, 11, 8, rp, rsubs, rlat);
        run8(5, 7, 11, 0, p, lat);
        start8 = 1'b1;
        @(negedge clk);
        chk("b2b_idle_gap", busy8, 0);
        @(negedge clk);
        chk("b2b_restart_clr", p_clr8, 1);
        lat = 1;
        while (!done8 && lat < 200) begin
            @(negedge clk);
            lat++;
            start8 = 1'b0;
        end
        chk("b2b_latency", lat, rlat);
        chk("b2b_p", p8, 2);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_stops", busy8, 0);
        chk("multi_hot8", multi_hot8, 0);

        // Random sweep on the 16-bit instance.
        for (int v = 0; v < 200; v++) begin
            longint m, x, y;
            m = longint'($urandom_range(65535, 2));
            x = longint'($urandom) % m;
            y = longint'($urandom) % m;
            ref_mm(x, y, m, 16, rp, rsubs, rlat);
            run16(x, y, m, p, lat);
            chk($sformatf("rnd%0d_p", v), p, (x * y) % m);
`ifdef MM_EARLY_SKIP_EN
            chk($sformatf("rnd%0d_latency", v), lat, rlat);
`else
            chk($sformatf("rnd%0d_latency", v), lat, CYCLES_PER_BIT * N16 + 2);
`endif
        end
        chk("multi_hot16", multi_hot16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
